pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline.
- Drives the stall, flush and hold controls of the IF/ID, ID/EX and EX/MEM pipeline registers, plus the EX-stage forwarding mux selects.
- Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits under one state machine with fixed priority.

Parameters:
REGBITS, 4, register-index width (2^REGBITS architectural registers; register 0 is hardwired zero)
FLUSH_CYCLES, 2, number of consecutive cycles fd_flush/de_flush stay asserted after a taken branch (legal range 1..15)

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  synchronous active-low reset
ex_rs1  in  REGBITS  source register 1 of the instruction in EX
ex_rs2  in  REGBITS  source register 2 of the instruction in EX
ex_use1  in  1  EX instruction reads rs1
ex_use2  in  1  EX instruction reads rs2
mem_dstReg  in  REGBITS  destination of the instruction in MEM
mem_regWrite  in  1  MEM instruction writes the register file
mem_memtoReg  in  1  MEM instruction is a load
wb_dstReg  in  REGBITS  destination of the instruction in WB
wb_regWrite  in  1  WB instruction writes the register file
branch_taken  in  1  EX resolved a taken branch or jump (redirect)
mem_busy  in  1  data memory not ready; MEM access incomplete
pc_stall  out  1  hold PC
fd_stall  out  1  hold IF/ID register
de_stall  out  1  hold ID/EX register
fd_flush  out  1  bubble into IF/ID
de_flush  out  1  bubble into ID/EX
em_flush  out  1  bubble into EX/MEM (clears memtoReg/memWrite/regWrite)
em_hold  out  1  hold EX/MEM register contents
fwd_sel1  out  2  EX operand 1 source: 00 regfile, 01 MEM aluOut, 10 WB result
fwd_sel2  out  2  EX operand 2 source, same encoding

Behaviour:
- Reset: rst_n sampled low at posedge -> state=RUN, flush counter=0, saved state=RUN. While rst_n is low, all stall/flush/hold outputs are forced 0 and fwd_sel1/fwd_sel2 are 00. Reset mid-stall or mid-flush aborts immediately.
- States: RUN, LD_STALL, BR_FLUSH, MEM_WAIT. Outputs are Mealy: a combinational decode of state and current inputs, valid in the same cycle.
- Forwarding, independent of state, evaluated per operand n:
  - 01 if ex_use_n && mem_regWrite && !mem_memtoReg && mem_dstReg==ex_rs_n && ex_rs_n!=0
  - else 10 if ex_use_n && wb_regWrite && wb_dstReg==ex_rs_n && ex_rs_n!=0
  - else 00. MEM match takes priority over WB match.
- load_use = mem_regWrite && mem_memtoReg && mem_dstReg!=0 && ((ex_use1 && ex_rs1==mem_dstReg) || (ex_use2 && ex_rs2==mem_dstReg)).
- Priority in every state: mem_busy > branch_taken > load_use.
- mem_busy=1 in any state:
  - Assert pc_stall, fd_stall, de_stall, em_hold; all flushes 0.
  - If not already in MEM_WAIT, save current state and go to MEM_WAIT.
  - Flush counter is frozen.
- MEM_WAIT, mem_busy=0: return to saved state with the counter untouched. Outputs for that cycle are decoded as if already in the saved state.
- RUN, branch_taken=1: assert fd_flush and de_flush this cycle.
  - FLUSH_CYCLES==1: stay in RUN.
  - Otherwise: counter=FLUSH_CYCLES-1, go to BR_FLUSH.
- RUN, load_use=1 (no branch, no mem_busy):
  - Assert pc_stall, fd_stall, de_stall, em_flush for exactly one cycle; go to LD_STALL.
  - Next cycle the load is in WB and the consumer forwards via 10.
- LD_STALL: no stall/flush outputs asserted; load_use is not evaluated; branch_taken is handled exactly as in RUN; otherwise go to RUN.
- BR_FLUSH: assert fd_flush and de_flush; decrement counter; go to RUN when counter reaches 0.
  - A new branch_taken in BR_FLUSH reloads counter=FLUSH_CYCLES-1.
- Simultaneous stall and flush on one register never occurs: stall wins only under mem_busy, where all flushes are 0.

Optional Feature:
- Macro: PIPE_HAZARD_STATS_EN.
- When defined, adds outputs stall_cycles (32) and flush_events (32).
  - stall_cycles increments each cycle pc_stall=1.
  - flush_events increments on each accepted branch_taken.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- When not defined: no counters and no extra ports; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 2 cycles with branch_taken=1, mem_busy=1 -> all outputs 0, fwd_sel=00; after release, state RUN.
- Load-use: mem_memtoReg=1, mem_regWrite=1, mem_dstReg=5, ex_rs1=5, ex_use1=1 -> pc/fd/de_stall=1 and em_flush=1 for 1 cycle; next cycle wb_dstReg=5, wb_regWrite=1 -> fwd_sel1=10, no stall.
- Forwarding priority: mem_dstReg=wb_dstReg=3, both regWrite=1, mem_memtoReg=0, ex_rs2=3, ex_use2=1 -> fwd_sel2=01. Repeat with ex_rs2=0 -> fwd_sel2=00.
- Branch, FLUSH_CYCLES=2: branch_taken pulse -> fd_flush=de_flush=1 for exactly 2 cycles. Second branch in the 2nd cycle -> flush extends to 3 cycles total.
- mem_busy for 3 cycles arriving during the 2nd BR_FLUSH cycle -> stall+em_hold=1 for 3 cycles, flushes 0; then 1 more flush cycle, then RUN.
- PIPE_HAZARD_STATS_EN defined: run the load-use case plus 3-cycle mem_busy -> stall_cycles=4, flush_events=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central hazard and sequencing controller for a 5-stage pipeline.
// Resolves load-use stalls, taken-branch flushes and data-memory waits under a
// single state machine. The fixed priority is mem_busy > branch_taken > load_use.
// Also drives the EX-stage forwarding mux selects.
//
// Parameters:
//   REGBITS      - register-index width (register 0 is hardwired zero)
//   FLUSH_CYCLES - cycles fd_flush/de_flush stay high after a taken branch (1..15)
//
// Ports:
//   clk, rst_n                    - clock, synchronous active-low reset
//   ex_rs1/ex_rs2, ex_use1/2      - EX-stage source registers and their use flags
//   mem_dstReg/regWrite/memtoReg  - MEM-stage writer information
//   wb_dstReg/regWrite            - WB-stage writer information
//   branch_taken, mem_busy        - redirect request, data-memory wait
//   pc_stall/fd_stall/de_stall    - hold PC, IF/ID and ID/EX
//   fd_flush/de_flush/em_flush    - bubble into IF/ID, ID/EX and EX/MEM
//   em_hold                       - hold EX/MEM
//   fwd_sel1/fwd_sel2             - 00 regfile, 01 MEM aluOut, 10 WB result
//
// Optional feature (macro PIPE_HAZARD_STATS_EN):
//   When the macro is defined, the module adds two saturating 32-bit outputs.
//   stall_cycles counts cycles with pc_stall=1.
//   flush_events counts accepted branch_taken events.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned REGBITS      = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [REGBITS-1:0] ex_rs1,
    input  logic [REGBITS-1:0] ex_rs2,
    input  logic               ex_use1,
    input  logic               ex_use2,
    input  logic [REGBITS-1:0] mem_dstReg,
    input  logic               mem_regWrite,
    input  logic               mem_memtoReg,
    input  logic [REGBITS-1:0] wb_dstReg,
    input  logic               wb_regWrite,
    input  logic               branch_taken,
    input  logic               mem_busy,
    output logic               pc_stall,
    output logic               fd_stall,
    output logic               de_stall,
    output logic               fd_flush,
    output logic               de_flush,
    output logic               em_flush,
    output logic               em_hold,
`ifdef PIPE_HAZARD_STATS_EN
    output logic [31:0]        stall_cycles,
    output logic [31:0]        flush_events,
`endif
    output logic [1:0]         fwd_sel1,
    output logic [1:0]         fwd_sel2
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_LD_STALL = 2'd1,
        S_BR_FLUSH = 2'd2,
        S_MEM_WAIT = 2'd3
    } state_t;

    localparam logic [3:0] RELOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    state_t     saved_q, saved_d;
    state_t     eff_state_s;
    logic [3:0] cnt_q, cnt_d;
    logic       load_use_s;
    logic       br_accept_s;

    // Forwarding select for one operand; a MEM-stage ALU result beats WB.
    function automatic logic [1:0] fwd_pick(
        input logic               use_n,
        input logic [REGBITS-1:0] rs_n,
        input logic [REGBITS-1:0] m_dst,
        input logic               m_rw,
        input logic               m_ld,
        input logic [REGBITS-1:0] w_dst,
        input logic               w_rw
    );
        logic [1:0] sel;
        if (use_n && (rs_n != '0) && m_rw && !m_ld && (m_dst == rs_n)) begin
            sel = 2'b01;
        end else if (use_n && (rs_n != '0) && w_rw && (w_dst == rs_n)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard decode, next-state logic and Mealy output decode.
    always_comb begin
        state_d  = state_q;
        saved_d  = saved_q;
        cnt_d    = cnt_q;
        pc_stall = 1'b0;
        fd_stall = 1'b0;
        de_stall = 1'b0;
        fd_flush = 1'b0;
        de_flush = 1'b0;
        em_flush = 1'b0;
        em_hold  = 1'b0;
        fwd_sel1 = fwd_pick(ex_use1, ex_rs1, mem_dstReg, mem_regWrite, mem_memtoReg,
                            wb_dstReg, wb_regWrite);
        fwd_sel2 = fwd_pick(ex_use2, ex_rs2, mem_dstReg, mem_regWrite, mem_memtoReg,
                            wb_dstReg, wb_regWrite);

        load_use_s = mem_regWrite && mem_memtoReg && (mem_dstReg != '0) &&
                     ((ex_use1 && (ex_rs1 == mem_dstReg)) ||
                      (ex_use2 && (ex_rs2 == mem_dstReg)));

        // Leaving MEM_WAIT decodes as the saved state in the same cycle.
        if (state_q == S_MEM_WAIT) begin
            eff_state_s = saved_q;
        end else begin
            eff_state_s = state_q;
        end

        br_accept_s = 1'b0;

        if (mem_busy) begin
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            de_stall = 1'b1;
            em_hold  = 1'b1;
            state_d  = S_MEM_WAIT;
            // Re-entering the wait keeps the original saved state.
            saved_d  = eff_state_s;
        end else begin
            case (eff_state_s)
                S_RUN, S_LD_STALL: begin
                    if (branch_taken) begin
                        br_accept_s = 1'b1;
                    end else if ((eff_state_s == S_RUN) && load_use_s) begin
                        pc_stall = 1'b1;
                        fd_stall = 1'b1;
                        de_stall = 1'b1;
                        em_flush = 1'b1;
                        state_d  = S_LD_STALL;
                    end else begin
                        state_d  = S_RUN;
                    end
                end
                S_BR_FLUSH: begin
                    fd_flush = 1'b1;
                    de_flush = 1'b1;
                    if (branch_taken) begin
                        br_accept_s = 1'b1;
                    end else if (cnt_q <= 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = S_RUN;
                    end else begin
                        cnt_d   = cnt_q - 4'd1;
                        state_d = S_BR_FLUSH;
                    end
                end
                default: begin
                    state_d = S_RUN;
                end
            endcase

            // Any accepted branch flushes now and (re)starts the flush window.
            if (br_accept_s) begin
                fd_flush = 1'b1;
                de_flush = 1'b1;
                if (FLUSH_CYCLES == 32'd1) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d   = RELOAD;
                    state_d = S_BR_FLUSH;
                end
            end else begin
                cnt_d = cnt_d;
            end
        end

        // Reset masks every control output in the same cycle.
        if (!rst_n) begin
            pc_stall    = 1'b0;
            fd_stall    = 1'b0;
            de_stall    = 1'b0;
            fd_flush    = 1'b0;
            de_flush    = 1'b0;
            em_flush    = 1'b0;
            em_hold     = 1'b0;
            fwd_sel1    = 2'b00;
            fwd_sel2    = 2'b00;
            br_accept_s = 1'b0;
        end else begin
            br_accept_s = br_accept_s;
        end
    end

    // State, saved-state and flush-counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            saved_q <= S_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;

    // Saturating event counters.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (pc_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
        if (br_accept_s && (flush_events_q != 32'hFFFF_FFFF)) begin
            flush_events_d = flush_events_q + 32'd1;
        end else begin
            flush_events_d = flush_events_q;
        end
    end

    // Counter registers, cleared on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_q <= 32'd0;
            flush_events_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// This is a self-checking bench for pipe_hazard_ctrl, built with the default
// parameters (REGBITS=4, FLUSH_CYCLES=2).
// A table of per-cycle records gives each cycle's inputs and expected outputs.
// Each record is driven on the falling edge, and its expected value is pushed
// to a queue. The record is then popped and compared shortly afterwards,
// before the next rising edge.
// A second phase uses random forwarding-only vectors, checked against a small
// reference model of the forwarding rules.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    typedef struct {
        logic        rst_n;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic        u1;
        logic        u2;
        logic [3:0]  md;
        logic        mrw;
        logic        mm;
        logic [3:0]  wd;
        logic        wrw;
        logic        br;
        logic        busy;
        logic [10:0] exp;
    } vec_t;

    // Output packing: {pc,fd_st,de_st,fd_fl,de_fl,em_fl,em_hold,fwd1[1:0],fwd2[1:0]}
    localparam logic [10:0] O_NONE = 11'b000_00_0_0_00_00;
    localparam logic [10:0] O_LU   = 11'b111_00_1_0_00_00;
    localparam logic [10:0] O_BR   = 11'b000_11_0_0_00_00;
    localparam logic [10:0] O_BUSY = 11'b111_00_0_1_00_00;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ex_rs1, ex_rs2, mem_dstReg, wb_dstReg;
    logic       ex_use1, ex_use2, mem_regWrite, mem_memtoReg, wb_regWrite;
    logic       branch_taken, mem_busy;
    logic       pc_stall, fd_stall, de_stall, fd_flush, de_flush, em_flush, em_hold;
    logic [1:0] fwd_sel1, fwd_sel2;
`ifdef PIPE_HAZARD_STATS_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    int          errors = 0;
    int          checks = 0;
    int          exp_stalls = 0;
    int          exp_flushes = 0;
    logic [10:0] exp_q[$];
    vec_t        tbl[$];

    pipe_hazard_ctrl #(.REGBITS(4), .FLUSH_CYCLES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_use1      (ex_use1),
        .ex_use2      (ex_use2),
        .mem_dstReg   (mem_dstReg),
        .mem_regWrite (mem_regWrite),
        .mem_memtoReg (mem_memtoReg),
        .wb_dstReg    (wb_dstReg),
        .wb_regWrite  (wb_regWrite),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .pc_stall     (pc_stall),
        .fd_stall     (fd_stall),
        .de_stall     (de_stall),
        .fd_flush     (fd_flush),
        .de_flush     (de_flush),
        .em_flush     (em_flush),
        .em_hold      (em_hold),
`ifdef PIPE_HAZARD_STATS_EN
        .stall_cycles (stall_cycles),
        .flush_events (flush_events),
`endif
        .fwd_sel1     (fwd_sel1),
        .fwd_sel2     (fwd_sel2)
    );

    // 10-time-unit clock.
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [3:0] rs1, input logic [3:0] rs2,
                                input logic u1, input logic u2, input logic [3:0] md,
                                input logic mrw, input logic mm, input logic [3:0] wd,
                                input logic wrw, input logic br, input logic busy,
                                input logic [10:0] exp);
        vec_t v;
        v.rst_n = r;  v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.md = md;    v.mrw = mrw; v.mm = mm;   v.wd = wd; v.wrw = wrw;
        v.br = br;    v.busy = busy; v.exp = exp;
        return v;
    endfunction

    // Independent reference for one operand's forwarding select.
    function automatic logic [1:0] ref_fwd(input logic u, input logic [3:0] rs,
                                           input logic [3:0] md, input logic mrw,
                                           input logic mm, input logic [3:0] wd,
                                           input logic wrw);
        if (u && rs != 4'd0 && mrw && !mm && md == rs) return 2'b01;
        if (u && rs != 4'd0 && wrw && wd == rs) return 2'b10;
        return 2'b00;
    endfunction

    // Drive one cycle, queue its expectation, then pop and compare it.
    task automatic apply(input vec_t v, input string name);
        logic [10:0] got;
        logic [10:0] want;
        @(negedge clk);
        rst_n        = v.rst_n;
        ex_rs1       = v.rs1;  ex_rs2       = v.rs2;
        ex_use1      = v.u1;   ex_use2      = v.u2;
        mem_dstReg   = v.md;   mem_regWrite = v.mrw; mem_memtoReg = v.mm;
        wb_dstReg    = v.wd;   wb_regWrite  = v.wrw;
        branch_taken = v.br;   mem_busy     = v.busy;
        exp_q.push_back(v.exp);
        // Statistics model, effective at the coming rising edge.
        if (!v.rst_n) begin
            exp_stalls  = 0;
            exp_flushes = 0;
        end else begin
            exp_stalls  = exp_stalls + int'(v.exp[10]);
            exp_flushes = exp_flushes + int'(v.br && !v.busy);
        end
        #2;
        got  = {pc_stall, fd_stall, de_stall, fd_flush, de_flush, em_flush, em_hold,
                fwd_sel1, fwd_sel2};
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    initial begin
        rst_n = 1'b0; ex_rs1 = 4'd0; ex_rs2 = 4'd0; ex_use1 = 1'b0; ex_use2 = 1'b0;
        mem_dstReg = 4'd0; mem_regWrite = 1'b0; mem_memtoReg = 1'b0;
        wb_dstReg = 4'd0; wb_regWrite = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;

        //            rst rs1   rs2   u1 u2 md    mrw mm wd    wrw br busy exp
        // Reset with branch/busy/forward matches present: everything masked.
        tbl.push_back(mk(0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 1, O_NONE));
        tbl.push_back(mk(0, 4'd3, 4'd0, 1, 0, 4'd3, 1, 0, 4'd0, 0, 1, 1, O_NONE));
        tbl.push_back(mk(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, O_NONE));
        // Load-use: a one-cycle stall, then WB forwarding with no stall.
        tbl.push_back(mk(1, 4'd5, 4'd0, 1, 0, 4'd5, 1, 1, 4'd0, 0, 0, 0, O_LU));
        tbl.push_back(mk(1, 4'd5, 4'd0, 1, 0, 4'd0, 0, 0, 4'd5, 1, 0, 0, 11'b000_00_0_0_10_00));
        tbl.push_back(mk(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, O_NONE));
        // Forwarding priority: MEM beats WB; r0 is never forwarded; no use means no forward.
        tbl.push_back(mk(1, 4'd0, 4'd3, 0, 1, 4'd3, 1, 0, 4'd3, 1, 0, 0, 11'd1));
        tbl.push_back(mk(1, 4'd0, 4'd0, 0, 1, 4'd3, 1, 0, 4'd3, 1, 0, 0, O_NONE));
        tbl.push_back(mk(1, 4'd0, 4'd3, 0, 0, 4'd3, 1, 0, 4'd3, 1, 0, 0, O_NONE));
        tbl.push_back(mk(1, 4'd0, 4'd3, 0, 1, 4'd3, 0, 0, 4'd3, 1, 0, 0, 11'd2));
        // A branch pulse gives exactly two flush cycles.
        tbl.push_back(mk(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 0, O_BR));
        tbl.push_back(mk(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, O_BR));
        tbl.push_back(mk(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, O_NONE));
        // A second branch in the 2nd flush cycle extends the flush to three cycles.
        tbl.push_back(mk(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 0, O_BR));
        tbl.push_back(mk(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 0, O_BR));
        tbl.push_back(mk(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, O_BR));
        tbl.push_back(mk(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, O_NONE));
        // mem_busy for 3 cycles during the 2nd flush cycle; one flush cycle remains afterwards.
        tbl.push_back(mk(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 0, O_BR));
        tbl.push_back(mk(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 1, O_BUSY));
        tbl.push_back(mk(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 1, O_BUSY));
        tbl.push_back(mk(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 1, O_BUSY));
        tbl.push_back(mk(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, O_BR));
        tbl.push_back(mk(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, O_NONE));
        // busy beats load-use; after the wait the load-use is taken; LD_STALL ignores load_use.
        tbl.push_back(mk(1, 4'd7, 4'd0, 1, 0, 4'd7, 1, 1, 4'd0, 0, 0, 1, O_BUSY));
        tbl.push_back(mk(1, 4'd7, 4'd0, 1, 0, 4'd7, 1, 1, 4'd0, 0, 0, 0, O_LU));
        tbl.push_back(mk(1, 4'd7, 4'd0, 1, 0, 4'd7, 1, 1, 4'd0, 0, 0, 0, O_NONE));
        // A branch beats load-use; a reset mid-flush aborts the flush.
        tbl.push_back(mk(1, 4'd0, 4'd9, 0, 1, 4'd9, 1, 1, 4'd0, 0, 1, 0, O_BR));
        tbl.push_back(mk(0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, O_NONE));
        tbl.push_back(mk(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, O_NONE));
        // A branch in LD_STALL is handled as in RUN.
        tbl.push_back(mk(1, 4'd0, 4'd2, 0, 1, 4'd2, 1, 1, 4'd0, 0, 0, 0, O_LU));
        tbl.push_back(mk(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 0, O_BR));
        tbl.push_back(mk(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, O_BR));
        tbl.push_back(mk(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, O_NONE));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("row%0d", i));
        end

        // Random forwarding-only vectors; with no loads or branches, the FSM stays in RUN.
        for (int k = 0; k < 24; k++) begin
            vec_t v;
            v = mk(1, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0,
                   4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, O_NONE);
            v.exp[3:2] = ref_fwd(v.u1, v.rs1, v.md, v.mrw, v.mm, v.wd, v.wrw);
            v.exp[1:0] = ref_fwd(v.u2, v.rs2, v.md, v.mrw, v.mm, v.wd, v.wrw);
            apply(v, $sformatf("fwd_rand%0d", k));
        end

        @(negedge clk);
`ifdef PIPE_HAZARD_STATS_EN
        checks++;
        if (stall_cycles !== 32'(exp_stalls)) begin
            errors++;
            $display("FAIL stall_cycles: got %0d expected %0d", stall_cycles, exp_stalls);
        end
        checks++;
        if (flush_events !== 32'(exp_flushes)) begin
            errors++;
            $display("FAIL flush_events: got %0d expected %0d", flush_events, exp_flushes);
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
